// File: rtl/msc_addr_seq_if.sv
// Control, status and ROM bus bundle for msc_addr_seq.
interface msc_addr_seq_if #(
    parameter int MSC_N = 4,
    parameter int AW    = 10,
    parameter int QW    = 6,
    parameter int VW    = 10
);
    logic [MSC_N-1:0] start;
    logic             stop;
    logic             pause;
    logic             loop_en;
    logic [VW-1:0]    volume_in;
    logic [QW-1:0]    q;
    logic [AW-1:0]    addr;
    logic             rom_clock;
    logic [QW-1:0]    note_out;
    logic [VW-1:0]    volume_out;
    logic             tran_vld;
    logic             tran_end;
    logic             busy;

    modport slave (
        input  start, stop, pause, loop_en, volume_in, q,
        output addr, rom_clock, note_out, volume_out, tran_vld, tran_end, busy
    );
    modport master (
        output start, stop, pause, loop_en, volume_in, q,
        input  addr, rom_clock, note_out, volume_out, tran_vld, tran_end, busy
    );
endinterface

// File: rtl/msc_addr_seq.sv
// Music ROM address sequencer: walks a song segment note by note, HOLD cycles per note.
// Define MSC_LOOP_EN to let loop_en replay a song when it ends.
module msc_addr_seq #(
    parameter int MSC_N  = 4,
    parameter int AW     = 10,
    parameter int SEG_AW = 8,
    parameter int QW     = 6,
    parameter int VW     = 10,
    parameter int HOLD   = 50
) (
    input logic           sysclk,
    input logic           rst_n,
    msc_addr_seq_if.slave bus
);
    localparam int SW = (MSC_N > 1) ? $clog2(MSC_N) : 1;
    localparam int CW = $clog2(HOLD);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] FETCH = 3'd1;
    localparam logic [2:0] WAIT  = 3'd2;
    localparam logic [2:0] PLAY  = 3'd3;
    localparam logic [2:0] PAUSE = 3'd4;
    localparam logic [2:0] DONE  = 3'd5;

    logic [2:0]    state, nxt;
    logic [AW-1:0] addr_r, nxt_addr;
    logic [CW-1:0] cnt, nxt_cnt;
    logic [SW-1:0] song, nxt_song, req_k;
    logic [QW-1:0] note_r, nxt_note;
    logic          vld_nxt, end_nxt, loop_now;
    logic          rom_clk_r, vld_r, end_r, busy_r;
    logic [VW-1:0] vol_r;

    function automatic logic [AW-1:0] base_of(input logic [SW-1:0] k);
        return AW'(k) << SEG_AW;
    endfunction

`ifdef MSC_LOOP_EN
    assign loop_now = bus.loop_en;
`else
    logic unused_loop_en;
    assign unused_loop_en = bus.loop_en;
    assign loop_now       = 1'b0;
`endif

    // lowest set request bit wins
    always_comb begin
        req_k = '0;
        for (int i = MSC_N - 1; i >= 0; i--)
            if (bus.start[i]) req_k = SW'(i);
    end

    always_comb begin
        nxt      = state;
        nxt_addr = addr_r;
        nxt_cnt  = cnt;
        nxt_song = song;
        nxt_note = note_r;
        vld_nxt  = 1'b0;
        end_nxt  = 1'b0;
        case (state)
            IDLE:  nxt = IDLE;
            FETCH: nxt = WAIT;
            WAIT: begin
                if (bus.q == '0) begin
                    nxt = DONE;
                end else begin
                    nxt      = PLAY;
                    nxt_note = bus.q;
                    vld_nxt  = 1'b1;
                    nxt_cnt  = '0;
                end
            end
            PLAY: begin
                // the cycle that sees pause still counts, so a pause of N cycles stretches the note by N
                if (cnt == CW'(HOLD - 1)) begin
                    if (&addr_r[SEG_AW-1:0]) begin
                        nxt = DONE;
                    end else begin
                        nxt      = FETCH;
                        nxt_addr = addr_r + 1'b1;
                    end
                end else begin
                    nxt_cnt = cnt + 1'b1;
                    if (bus.pause) nxt = PAUSE;
                end
            end
            PAUSE: if (!bus.pause) nxt = PLAY;
            DONE: begin
                if (loop_now) begin
                    nxt      = FETCH;
                    nxt_addr = base_of(song);
                end else begin
                    nxt     = IDLE;
                    end_nxt = 1'b1;
                end
            end
            default: nxt = IDLE;
        endcase
        if (|bus.start) begin
            nxt      = FETCH;
            nxt_addr = base_of(req_k);
            nxt_song = req_k;
            nxt_note = note_r;
            vld_nxt  = 1'b0;
            end_nxt  = 1'b0;
        end
        if (bus.stop) begin
            nxt      = IDLE;
            nxt_note = note_r;
            vld_nxt  = 1'b0;
            end_nxt  = 1'b0;
        end
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr_r    <= '0;
            cnt       <= '0;
            song      <= '0;
            note_r    <= '0;
            rom_clk_r <= 1'b0;
            vld_r     <= 1'b0;
            end_r     <= 1'b0;
            busy_r    <= 1'b0;
            vol_r     <= '0;
        end else begin
            state     <= nxt;
            addr_r    <= nxt_addr;
            cnt       <= nxt_cnt;
            song      <= nxt_song;
            note_r    <= nxt_note;
            rom_clk_r <= (nxt == FETCH);
            vld_r     <= vld_nxt;
            end_r     <= end_nxt;
            busy_r    <= (nxt != IDLE);
            vol_r     <= (nxt == PLAY) ? bus.volume_in : '0;
        end
    end

    assign bus.addr       = addr_r;
    assign bus.rom_clock  = rom_clk_r;
    assign bus.note_out   = note_r;
    assign bus.volume_out = vol_r;
    assign bus.tran_vld   = vld_r;
    assign bus.tran_end   = end_r;
    assign bus.busy       = busy_r;
endmodule
